// File: rtl/ula_seq.sv
// ula_seq: four-phase instruction sequencer around an external ula.
// Holds an 8x8 register file (R0 hardwired to zero), fetches operands,
// hands them to the ula, captures the result and writes it back.
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready high
// READ  | register operands and op presented to the ula
// EXEC  | ula result (or immediate) captured into result/zero/carry
// WB    | captured result written to R[rd], done raised on the way out
module ula_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rs1,
  input  logic [2:0] instr_rs2,
  input  logic [7:0] instr_imm,
  output logic [7:0] SrcA,
  output logic [7:0] SrcB,
  output logic [2:0] ULAControl,
  input  logic [7:0] ULAResult,
  input  logic       Flag_z,
  input  logic       CarryOut,
  output logic       done,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry
);

  localparam logic [2:0] OP_LI = 3'b100;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     state_q, state_d;
  logic       ready_q;
  logic       done_q;
  logic [2:0] op_q, rd_q, rs1_q, rs2_q;
  logic [7:0] imm_q;
  logic [7:0] srca_q, srcb_q;
  logic [2:0] ctl_q;
  logic [7:0] result_q;
  logic       zero_q, carry_q;
  logic [7:0] rf_q [8];

  // Next-state decode; only the IDLE exit waits on a handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer datapath, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      ctl_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            rd_q    <= instr_rd;
            rs1_q   <= instr_rs1;
            rs2_q   <= instr_rs2;
            imm_q   <= instr_imm;
            ready_q <= 1'b0;
          end
        end
        READ: begin
          // Operands stay on the ula ports until the next instruction reads.
          srca_q <= rf_q[rs1_q];
          srcb_q <= rf_q[rs2_q];
          ctl_q  <= op_q;
        end
        EXEC: begin
          // Load-immediate bypasses the ula; invalid ops take what it returns.
          if (op_q == OP_LI) begin
            result_q <= imm_q;
            zero_q   <= (imm_q == 8'd0);
            carry_q  <= 1'b0;
          end else begin
            result_q <= ULAResult;
            zero_q   <= Flag_z;
            carry_q  <= CarryOut;
          end
        end
        WB: begin
          // R0 is never written so it keeps its reset value of zero.
          if (rd_q != 3'd0) rf_q[rd_q] <= result_q;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign SrcA        = srca_q;
  assign SrcB        = srcb_q;
  assign ULAControl  = ctl_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign carry       = carry_q;

endmodule
